// File: rtl/mem_pkg.sv
// Shared types, funct3 encodings and byte-lane helpers for the RV64 MEM stage.
package mem_pkg;
    localparam int XLEN   = 64;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } mem_size_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    function automatic mem_size_e size_of(input logic [2:0] funct3);
        return mem_size_e'(funct3[1:0]);
    endfunction

    function automatic logic [7:0] byte_enable(input mem_size_e size, input logic [2:0] a);
        logic [7:0] be;
        case (size)
            SZ_B:    be = 8'h01 << a;
            SZ_H:    be = 8'h03 << {a[2:1], 1'b0};
            SZ_W:    be = 8'h0F << {a[2], 2'b00};
            SZ_D:    be = 8'hFF;
            default: be = 8'hFF;
        endcase
        return be;
    endfunction

    // Replicate the store operand across every lane so any enabled lane carries it.
    function automatic logic [XLEN-1:0] store_format(input mem_size_e size, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] w;
        case (size)
            SZ_B:    w = {8{d[7:0]}};
            SZ_H:    w = {4{d[15:0]}};
            SZ_W:    w = {2{d[31:0]}};
            SZ_D:    w = d;
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic is_aligned(input mem_size_e size, input logic [2:0] a);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = ~a[0];
            SZ_W:    ok = (a[1:0] == 2'b00);
            SZ_D:    ok = (a == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction
endpackage

// File: rtl/load_align.sv
// Load lane selection: picks the addressed byte/half/word out of the returned
// doubleword and sign- or zero-extends it to XLEN.
module load_align
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);
    mem_size_e       size_s;
    logic [5:0]      shamt_s;
    logic [XLEN-1:0] shifted_s;
    logic            sext_s;

    assign size_s = size_of(funct3);
    assign sext_s = ~funct3[2];

    // Shift the addressed lane down to bit 0, then extend it.
    always_comb begin
        shamt_s   = 6'd0;
        shifted_s = '0;
        result    = '0;
        case (size_s)
            SZ_B:    shamt_s = {addr, 3'b000};
            SZ_H:    shamt_s = {addr[2:1], 4'b0000};
            SZ_W:    shamt_s = {addr[2], 5'b00000};
            SZ_D:    shamt_s = 6'd0;
            default: shamt_s = 6'd0;
        endcase
        shifted_s = rdata >> shamt_s;
        case (size_s)
            SZ_B:    result = {{56{sext_s & shifted_s[7]}},  shifted_s[7:0]};
            SZ_H:    result = {{48{sext_s & shifted_s[15]}}, shifted_s[15:0]};
            SZ_W:    result = {{32{sext_s & shifted_s[31]}}, shifted_s[31:0]};
            SZ_D:    result = shifted_s;
            default: result = shifted_s;
        endcase
    end
endmodule

// File: rtl/memory_access.sv
// RV64 MEM stage: captures EX results, runs loads/stores over a req/ack bus and
// feeds writeback. Optional misaligned-access trap under MEM_MISALIGN_TRAP_EN.
module memory_access
    import mem_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              reg_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [4:0]        rd_i,
    input  logic [XLEN-1:0]   alu_result_i,
    input  logic [XLEN-1:0]   wr_data_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [7:0]        dmem_be_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    input  logic              dmem_ack_i,
    output logic              stall_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misalign_o,
    output logic [XLEN-1:0]   badaddr_o,
`endif
    output logic [4:0]        rd_o,
    output logic              reg_write_o,
    output logic [XLEN-1:0]   result_o
);
    state_e          state_r;
    logic            reg_write_r;
    logic [4:0]      rd_r;
    logic [2:0]      funct3_r;
    logic [XLEN-1:0] alu_r;
`ifdef MEM_MISALIGN_TRAP_EN
    logic            misalign_r;
`endif

    mem_size_e       size_in_s;
    logic            is_mem_s;
    logic            misalign_s;
    logic            start_s;
    logic            capture_s;
    logic [XLEN-1:0] load_result_s;

    assign size_in_s = size_of(funct3_i);
    assign is_mem_s  = mem_read_i | mem_write_i;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_s = is_mem_s & ~is_aligned(size_in_s, alu_result_i[2:0]);
`else
    assign misalign_s = 1'b0;
`endif
    assign start_s   = is_mem_s & ~misalign_s;
    assign stall_o   = (state_r == ACCESS) & ~dmem_ack_i;
    assign capture_s = ~stall_o;

    load_align u_load_align (
        .rdata  (dmem_rdata_i),
        .addr   (alu_r[2:0]),
        .funct3 (funct3_r),
        .result (load_result_s)
    );

    // Stage FSM: writeback of the op in flight and capture of the next EX op.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= IDLE;
            reg_write_r  <= 1'b0;
            rd_r         <= 5'd0;
            funct3_r     <= 3'd0;
            alu_r        <= '0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= 8'h00;
            dmem_wdata_o <= '0;
            rd_o         <= 5'd0;
            reg_write_o  <= 1'b0;
            result_o     <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_r   <= 1'b0;
            misalign_o   <= 1'b0;
            badaddr_o    <= '0;
`endif
        end else begin
            case (state_r)
                ACCESS: begin
                    if (dmem_ack_i) begin
                        rd_o <= rd_r;
                        if (dmem_we_o) begin
                            reg_write_o <= 1'b0;
                        end else begin
                            reg_write_o <= reg_write_r;
                            result_o    <= load_result_s;
                        end
                    end else begin
                        reg_write_o <= 1'b0;
                    end
`ifdef MEM_MISALIGN_TRAP_EN
                    misalign_o <= 1'b0;
`endif
                end
                default: begin
                    rd_o <= rd_r;
`ifdef MEM_MISALIGN_TRAP_EN
                    misalign_o <= misalign_r;
                    if (misalign_r) begin
                        reg_write_o <= 1'b0;
                        badaddr_o   <= alu_r;
                    end else begin
                        reg_write_o <= reg_write_r;
                        result_o    <= alu_r;
                    end
`else
                    reg_write_o <= reg_write_r;
                    result_o    <= alu_r;
`endif
                end
            endcase

            // The bus fields stay frozen while stalled because capture is blocked.
            if (capture_s) begin
                state_r      <= start_s ? ACCESS : IDLE;
                reg_write_r  <= reg_write_i;
                rd_r         <= rd_i;
                funct3_r     <= funct3_i;
                alu_r        <= alu_result_i;
                dmem_req_o   <= start_s;
                dmem_we_o    <= start_s & mem_write_i;
                dmem_addr_o  <= {alu_result_i[ADDR_W-1:3], 3'b000};
                dmem_be_o    <= byte_enable(size_in_s, alu_result_i[2:0]);
                dmem_wdata_o <= store_format(size_in_s, wr_data_i);
`ifdef MEM_MISALIGN_TRAP_EN
                misalign_r   <= misalign_s;
`endif
            end
        end
    end
endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: byte-addressed reference memory, bus
// responder with variable ack latency, and a writeback/request monitor.
module tb_memory_access;
    import mem_pkg::*;

    typedef struct { logic [4:0] rd; logic [63:0] val; } wb_t;
    typedef struct { logic we; logic [31:0] addr; logic [7:0] be; logic [63:0] wdata; } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, reg_write;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [63:0] alu_result, wr_data;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr;
    logic [7:0]  dmem_be;
    logic [63:0] dmem_wdata, dmem_rdata;
    logic        stall;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic [63:0] result;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
    logic [63:0] badaddr;
    logic [63:0] exp_trap [$];
`endif

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int forced_delay = -1;
    int stray_req = 0;
    int stall_cnt = 0;
    int wb_cyc_last = 0, wb_cyc_prev = 0;

    wb_t  exp_wb  [$];
    req_t exp_req [$];
    logic [7:0]  mbyte [logic [31:0]];
    logic [63:0] dev   [logic [28:0]];

    memory_access dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_read_i(mem_read), .mem_write_i(mem_write), .reg_write_i(reg_write),
        .funct3_i(funct3), .rd_i(rd), .alu_result_i(alu_result), .wr_data_i(wr_data),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata), .dmem_rdata_i(dmem_rdata),
        .dmem_ack_i(dmem_ack), .stall_o(stall),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_o(misalign), .badaddr_o(badaddr),
`endif
        .rd_o(rd_out), .reg_write_o(reg_write_out), .result_o(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return 8'(a * 32'd37 + 32'd11);
    endfunction

    function automatic logic [7:0] mget(input logic [31:0] a);
        if (mbyte.exists(a)) return mbyte[a];
        return init_byte(a);
    endfunction

    function automatic logic [63:0] dget(input logic [28:0] idx);
        logic [63:0] w;
        if (dev.exists(idx)) return dev[idx];
        for (int i = 0; i < 8; i++) w[8*i +: 8] = init_byte({idx, 3'b000} + 32'(i));
        return w;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [63:0] d);
        for (int i = 0; i < 8; i++) mbyte[a + 32'(i)] = d[8*i +: 8];
        dev[a[31:3]] = d;
    endtask

    // Drive one EX op, hold it until the stage accepts it, then update the model.
    task automatic issue_op(input logic mr, input logic mw, input logic rw, input logic [2:0] f3,
                            input logic [4:0] r, input logic [63:0] alu, input logic [63:0] wd);
        int n, guard;
        logic [31:0] a, start;
        logic [63:0] v;
        req_t q;
        @(negedge clk);
        mem_read = mr; mem_write = mw; reg_write = rw; funct3 = f3;
        rd = r; alu_result = alu; wr_data = wd;
        #2;
        guard = 0;
        while (stall && guard < 60) begin
            @(negedge clk); #2; guard++;
        end
        if (stall) begin
            $display("FAIL stall_timeout: actual stall %0d after %0d cycles, required 0", stall, guard);
            $fatal(1, "stall never released");
        end
        @(posedge clk);
        n = 1 << f3[1:0];
        a = alu[31:0];
        start = a & ~32'(n - 1);
`ifdef MEM_MISALIGN_TRAP_EN
        if ((mr | mw) && (a != start)) exp_trap.push_back(alu);
        else
`endif
        if (mr | mw) begin
            q.we = mw; q.addr = {a[31:3], 3'b000}; q.be = 8'h00; q.wdata = '0;
            for (int i = 0; i < n; i++) q.be[int'(start[2:0]) + i] = 1'b1;
            if (mw) begin
                for (int j = 0; j < 8; j++) q.wdata[8*j +: 8] = wd[8*(j % n) +: 8];
                for (int i = 0; i < n; i++) mbyte[start + 32'(i)] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mget(start + 32'(i));
                if (!f3[2] && n < 8)
                    for (int i = 8*n; i < 64; i++) v[i] = v[8*n-1];
                if (rw) exp_wb.push_back('{rd: r, val: v});
            end
            exp_req.push_back(q);
        end else if (rw) begin
            exp_wb.push_back('{rd: r, val: alu});
        end
    endtask

    task automatic nop(input int k);
        for (int i = 0; i < k; i++) issue_op(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 64'd0, 64'd0);
    endtask

    // Data-memory responder: checks each new request and acks after a chosen latency.
    initial begin : responder
        int wait_cnt, stray_done;
        logic [31:0] held_addr;
        logic [63:0] w;
        req_t q;
        wait_cnt = -1; stray_done = 0; held_addr = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        forever begin
            @(negedge clk);
            dmem_ack = 1'b0;
            if (!rst_n) begin
                wait_cnt = -1;
            end else if (stray_req != stray_done) begin
                stray_done++;
                dmem_ack = 1'b1;
                dmem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
            end else if (dmem_req) begin
                if (wait_cnt < 0) begin
                    if (exp_req.size() == 0) begin
                        check("unexpected_req", 64'(dmem_req), 64'd0);
                    end else begin
                        q = exp_req.pop_front();
                        check("req_we", 64'(dmem_we), 64'(q.we));
                        check("req_addr", 64'(dmem_addr), 64'(q.addr));
                        check("req_be", 64'(dmem_be), 64'(q.be));
                        if (q.we) check("req_wdata", dmem_wdata, q.wdata);
                    end
                    held_addr = dmem_addr;
                    wait_cnt = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, 3));
                end else begin
                    check("req_addr_held", 64'(dmem_addr), 64'(held_addr));
                end
                if (wait_cnt == 0) begin
                    dmem_ack = 1'b1;
                    w = dget(dmem_addr[31:3]);
                    dmem_rdata = w;
                    if (dmem_we) begin
                        for (int j = 0; j < 8; j++)
                            if (dmem_be[j]) w[8*j +: 8] = dmem_wdata[8*j +: 8];
                        dev[dmem_addr[31:3]] = w;
                    end
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Writeback monitor: every reg_write_o pulse must match the head of the scoreboard.
    initial begin : monitor
        wb_t e;
        forever begin
            @(negedge clk); #3;
            if (rst_n) begin
                if (stall) stall_cnt++;
                if (reg_write_out) begin
                    if (exp_wb.size() == 0) begin
                        check("unexpected_wb", 64'(reg_write_out), 64'd0);
                    end else begin
                        e = exp_wb.pop_front();
                        check("wb_rd", 64'(rd_out), 64'(e.rd));
                        check("wb_result", result, e.val);
                        wb_cyc_prev = wb_cyc_last;
                        wb_cyc_last = cyc;
                    end
                end
`ifdef MEM_MISALIGN_TRAP_EN
                if (misalign) begin
                    if (exp_trap.size() == 0) check("unexpected_trap", 64'(misalign), 64'd0);
                    else check("badaddr", badaddr, exp_trap.pop_front());
                end
`endif
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_miss %0d", n_miss);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int s0;
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; funct3 = 3'd0;
        rd = 5'd0; alu_result = '0; wr_data = '0;
        #12;
        check("rst_req", 64'(dmem_req), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_reg_write", 64'(reg_write_out), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_rd", 64'(rd_out), 64'd0);
        check("rst_be", 64'(dmem_be), 64'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("rst_misalign", 64'(misalign), 64'd0);
        check("rst_badaddr", badaddr, 64'd0);
`endif
        @(negedge clk); rst_n = 1'b1;

        issue_op(1'b0, 1'b0, 1'b1, 3'd0, 5'd5, 64'h1234, 64'd0);
        nop(2);

        poke(32'h1000, 64'h0000_0000_8000_0000);
        forced_delay = 0;
        issue_op(1'b1, 1'b0, 1'b1, F3_LB,  5'd10, 64'h1003, 64'd0);
        issue_op(1'b1, 1'b0, 1'b1, F3_LBU, 5'd11, 64'h1003, 64'd0);
        nop(2);

        forced_delay = 3;
        issue_op(1'b0, 1'b1, 1'b1, F3_SH, 5'd7, 64'h2006, 64'hABCD);
        s0 = stall_cnt;
        nop(2);
        check("sh_stall_cycles", 64'(stall_cnt - s0), 64'd3);
        nop(1);

        forced_delay = 0;
        poke(32'h0100, 64'h1122_3344_5566_7788);
        poke(32'h0108, 64'h99AA_BBCC_DDEE_FF00);
        s0 = stall_cnt;
        issue_op(1'b1, 1'b0, 1'b1, F3_LD, 5'd3, 64'h0100, 64'd0);
        issue_op(1'b1, 1'b0, 1'b1, F3_LD, 5'd4, 64'h0108, 64'd0);
        nop(2);
        check("b2b_stall_cycles", 64'(stall_cnt - s0), 64'd0);
        check("b2b_result_spacing", 64'(wb_cyc_last - wb_cyc_prev), 64'd1);

        forced_delay = 20;
        issue_op(1'b1, 1'b0, 1'b1, F3_LD, 5'd9, 64'h0100, 64'd0);
        @(negedge clk);
        mem_read = 1'b0; reg_write = 1'b0; rd = 5'd0; alu_result = '0;
        @(negedge clk); #4;
        rst_n = 1'b0;
        #1;
        check("midrst_req", 64'(dmem_req), 64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        check("midrst_reg_write", 64'(reg_write_out), 64'd0);
        check("midrst_result", result, 64'd0);
        exp_wb.delete();
        forced_delay = -1;
        @(negedge clk); @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        stray_req++;
        repeat (3) @(posedge clk);
        #1;
        check("stray_ack_result", result, 64'd0);
        check("stray_ack_reg_write", 64'(reg_write_out), 64'd0);
        check("stray_ack_req", 64'(dmem_req), 64'd0);
        check("stray_ack_stall", 64'(stall), 64'd0);

        for (int k = 0; k < 300; k++) begin
            int kind;
            logic [2:0]  f3;
            logic [63:0] a;
            kind = int'($urandom_range(0, 7));
            f3 = 3'($urandom_range(0, 7));
            a = 64'(32'h1000 + $urandom_range(0, 63));
`ifdef MEM_MISALIGN_TRAP_EN
            a = a & ~(64'(1 << f3[1:0]) - 64'd1);
`endif
            if (kind < 4)
                issue_op(1'b1, 1'b0, 1'($urandom_range(0, 1)), f3, 5'($urandom), a, 64'd0);
            else if (kind < 6)
                issue_op(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), f3,
                         5'($urandom), a, {$urandom, $urandom});
            else
                issue_op(1'b0, 1'b0, 1'($urandom_range(0, 1)), f3, 5'($urandom),
                         {$urandom, $urandom}, 64'd0);
        end
        nop(6);

`ifdef MEM_MISALIGN_TRAP_EN
        issue_op(1'b1, 1'b0, 1'b1, F3_LW, 5'd12, 64'h3002, 64'd0);
        nop(4);
        check("trap_drained", 64'(exp_trap.size()), 64'd0);
`endif

        check("wb_drained", 64'(exp_wb.size()), 64'd0);
        check("req_drained", 64'(exp_req.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
